// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port, 1-cycle-latency system RAM between the
// paged CPU bus (read/write) and the video fetch unit (read-only).
module ram_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_page,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  output logic        ram_cs,
  output logic        ram_rw,
  output logic        ram_read,
  output logic [18:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_reg, state_next;
  logic   last_reg;   // last port served: 0 = CPU, 1 = video
  logic   port_reg;   // port owning the transaction in flight
  logic   read_reg;
  logic   cpu_pend, vid_pend, cpu_allowed;
  logic   grant, grant_vid;

  // A port is masked during its own ack cycle so a stale request is not re-served
  assign cpu_pend = cpu_req & ~cpu_ack;
  assign vid_pend = vid_req & ~vid_ack;

  // Strict priority: a raised video request, even a masked one, holds the CPU off
  assign cpu_allowed = FAIR ? cpu_pend : (cpu_pend & ~vid_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_vid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vid_pend || cpu_allowed) begin
          grant      = 1'b1;
          state_next = ISSUE;
          if (vid_pend && cpu_allowed) begin
            grant_vid = ~last_reg;
          end else begin
            grant_vid = vid_pend;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        state_next = IDLE;
        if (port_reg ? cpu_allowed : vid_pend) begin
          grant      = 1'b1;
          grant_vid  = ~port_reg;
          state_next = ISSUE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_reg  <= 1'b0;
      port_reg  <= 1'b0;
      read_reg  <= 1'b0;
      ram_cs    <= 1'b0;
      ram_rw    <= 1'b1;
      ram_read  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      vid_ack  <= 1'b0;
      ram_cs   <= 1'b0;
      ram_read <= 1'b0;
      ram_rw   <= 1'b1;

      // ram_rdata is valid during WAIT; complete the transaction at its end
      if (state_reg == WAIT) begin
        last_reg <= port_reg;
        if (port_reg) begin
          vid_ack   <= 1'b1;
          vid_rdata <= ram_rdata;
        end else begin
          cpu_ack <= 1'b1;
          if (read_reg) begin
            cpu_rdata <= ram_rdata;
          end
        end
      end

      if (grant) begin
        port_reg <= grant_vid;
        ram_cs   <= 1'b1;
        if (grant_vid) begin
          ram_addr <= vid_addr;
          ram_rw   <= 1'b1;
          ram_read <= 1'b1;
          read_reg <= 1'b1;
        end else begin
          ram_addr  <= {cpu_page, cpu_addr};
          ram_wdata <= cpu_wdata;
          ram_rw    <= cpu_rw;
          ram_read  <= cpu_rw;
          read_reg  <= cpu_rw;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vectors, multi-cycle corner
// sequences, and randomized two-port traffic against a transaction-level model.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Fair instance
  logic        cpu_req = 0, cpu_rw = 0, cpu_ack, vid_req = 0, vid_ack;
  logic [2:0]  cpu_page = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0]  cpu_wdata = 0, cpu_rdata, vid_rdata, ram_wdata, ram_rdata;
  logic [18:0] vid_addr = 0, ram_addr;
  logic        ram_cs, ram_rw, ram_read;

  // Video-priority instance
  logic        z_cpu_req = 0, z_cpu_rw = 0, z_cpu_ack, z_vid_req = 0, z_vid_ack;
  logic [2:0]  z_cpu_page = 0;
  logic [15:0] z_cpu_addr = 0;
  logic [7:0]  z_cpu_wdata = 0, z_cpu_rdata, z_vid_rdata, z_ram_wdata, z_ram_rdata;
  logic [18:0] z_vid_addr = 0, z_ram_addr;
  logic        z_ram_cs, z_ram_rw, z_ram_read;

  ram_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_page(cpu_page), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.FAIR(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_rw(z_cpu_rw), .cpu_page(z_cpu_page), .cpu_addr(z_cpu_addr),
    .cpu_wdata(z_cpu_wdata), .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
    .vid_req(z_vid_req), .vid_addr(z_vid_addr), .vid_rdata(z_vid_rdata), .vid_ack(z_vid_ack),
    .ram_cs(z_ram_cs), .ram_rw(z_ram_rw), .ram_read(z_ram_read), .ram_addr(z_ram_addr),
    .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata)
  );

  // Background RAM contents for never-written locations
  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ {a[15:11], a[18:16]} ^ 8'h3C;
  endfunction

  // RAM models: 1-cycle registered read, 0 when not reading
  logic [7:0]  mem [logic [18:0]];
  logic        poke_en = 0;
  logic [18:0] poke_addr = 0;
  logic [7:0]  poke_data = 0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] = poke_data;
    ram_rdata <= (ram_cs && ram_read) ? (mem.exists(ram_addr) ? mem[ram_addr] : pat(ram_addr)) : 8'h00;
    if (ram_cs && !ram_rw) mem[ram_addr] = ram_wdata;
  end
  always @(posedge clk) begin
    z_ram_rdata <= (z_ram_cs && z_ram_read) ? pat(z_ram_addr) : 8'h00;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {ram_cs, ram_rw, ram_read, ram_addr, ram_wdata, cpu_ack, vid_ack, cpu_rdata, vid_rdata};
  endfunction
  function automatic logic [47:0] outs0();
    return {z_ram_cs, z_ram_rw, z_ram_read, z_ram_addr, z_ram_wdata, z_cpu_ack, z_vid_ack, z_cpu_rdata, z_vid_rdata};
  endfunction
  logic [47:0] rst_exp = 48'h4000_0000_0000;  // only ram_rw high

  typedef struct {
    logic        vid;
    logic        rd;
    logic [2:0]  page;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        pre;
    logic [7:0]  pre_val;
    logic [18:0] exp_addr;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs [8];

  task automatic poke(input logic [18:0] a, input logic [7:0] d);
    poke_en = 1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 0;
  endtask

  // One isolated transaction on the fair instance, checked cycle by cycle
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    if (v.pre) poke(v.exp_addr, v.pre_val);
    if (v.vid) begin
      vid_req = 1; vid_addr = v.exp_addr;
    end else begin
      cpu_req = 1; cpu_rw = v.rd; cpu_page = v.page; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clk);
    check($sformatf("v%0d_issue_cs", i), 64'(ram_cs), 64'(1'b1));
    check($sformatf("v%0d_issue_addr", i), 64'(ram_addr), 64'(v.exp_addr));
    check($sformatf("v%0d_issue_rw_read", i), 64'({ram_rw, ram_read}), 64'({v.rd, v.rd}));
    if (!v.rd) check($sformatf("v%0d_issue_wdata", i), 64'(ram_wdata), 64'(v.wdata));
    @(negedge clk);
    check($sformatf("v%0d_wait_cs_ack", i), 64'({ram_cs, ram_read, cpu_ack, vid_ack}), 64'(4'b0000));
    @(negedge clk);
    check($sformatf("v%0d_ack", i), 64'({cpu_ack, vid_ack}), 64'(v.vid ? 2'b01 : 2'b10));
    check($sformatf("v%0d_rdata", i), 64'(v.vid ? vid_rdata : cpu_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d_ack_cs", i), 64'(ram_cs), 64'(1'b0));
    cpu_req = 0; vid_req = 0;
    @(negedge clk);
    check($sformatf("v%0d_ack_gone", i), 64'({cpu_ack, vid_ack, ram_cs}), 64'(3'b000));
    @(negedge clk);
  endtask

  typedef struct {logic [18:0] a; logic rw; logic [7:0] wd;} strobe_t;
  strobe_t     sq[$];
  strobe_t     s;
  logic [7:0]  ref_mem [32];
  logic [18:0] c_phys, v_phys;
  logic        c_rd, c_busy, v_busy, prev_cs, abort, got;
  logic [7:0]  c_wd, last_crd;
  int          c_wait, v_wait, ntx, nv, nc, ncs;
  localparam int NRND = 4000;

  initial begin
    vecs[0] = '{vid:1'b0, rd:1'b1, page:3'd3, addr:16'h1234, wdata:8'h00, pre:1'b1, pre_val:8'hA5, exp_addr:19'h31234, exp_rdata:8'hA5};
    vecs[1] = '{vid:1'b0, rd:1'b0, page:3'd0, addr:16'h0100, wdata:8'h5A, pre:1'b0, pre_val:8'h00, exp_addr:19'h00100, exp_rdata:8'hA5};
    vecs[2] = '{vid:1'b0, rd:1'b1, page:3'd0, addr:16'h0100, wdata:8'h00, pre:1'b0, pre_val:8'h00, exp_addr:19'h00100, exp_rdata:8'h5A};
    vecs[3] = '{vid:1'b1, rd:1'b1, page:3'd0, addr:16'h0000, wdata:8'h00, pre:1'b1, pre_val:8'hC3, exp_addr:19'h7FFFF, exp_rdata:8'hC3};
    vecs[4] = '{vid:1'b0, rd:1'b0, page:3'd7, addr:16'hFFFF, wdata:8'h81, pre:1'b0, pre_val:8'h00, exp_addr:19'h7FFFF, exp_rdata:8'h5A};
    vecs[5] = '{vid:1'b1, rd:1'b1, page:3'd0, addr:16'h0000, wdata:8'h00, pre:1'b0, pre_val:8'h00, exp_addr:19'h7FFFF, exp_rdata:8'h81};
    vecs[6] = '{vid:1'b0, rd:1'b1, page:3'd7, addr:16'hFFFF, wdata:8'h00, pre:1'b0, pre_val:8'h00, exp_addr:19'h7FFFF, exp_rdata:8'h81};
    vecs[7] = '{vid:1'b1, rd:1'b1, page:3'd0, addr:16'h0000, wdata:8'h00, pre:1'b0, pre_val:8'h00, exp_addr:19'h00000, exp_rdata:pat(19'd0)};

    // Reset values
    @(negedge clk);
    check("reset_outs", 64'(outs()), 64'(rst_exp));
    check("reset_outs_f0", 64'(outs0()), 64'(rst_exp));
    reset = 0;
    @(negedge clk);
    check("post_reset_idle", 64'(outs()), 64'(rst_exp));

    // Contention straight after reset: video first, then strict alternation
    vid_req = 1; vid_addr = 19'h10000;
    cpu_req = 1; cpu_rw = 1; cpu_page = 3'd0; cpu_addr = 16'h0010;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d_cs", k), 64'(ram_cs), 64'((k % 2 == 1) && (k <= 11)));
      check($sformatf("cont%0d_vack", k), 64'(vid_ack), 64'(k % 4 == 3));
      check($sformatf("cont%0d_cack", k), 64'(cpu_ack), 64'((k >= 5) && (k % 4 == 1)));
      if (k == 1) check("cont_first_addr", 64'(ram_addr), 64'(19'h10000));
      if (k == 3) check("cont_cpu_addr", 64'(ram_addr), 64'(19'h00010));
      if (vid_ack) check($sformatf("cont%0d_vdata", k), 64'(vid_rdata), 64'(pat(19'h10000)));
      if (cpu_ack) check($sformatf("cont%0d_cdata", k), 64'(cpu_rdata), 64'(pat(19'h00010)));
      if (k == 11) vid_req = 0;
      if (k == 13) cpu_req = 0;
    end

    // Video-priority instance: held video starves the CPU until it drops
    z_vid_req = 1; z_vid_addr = 19'h00020;
    z_cpu_req = 1; z_cpu_rw = 1; z_cpu_page = 3'd0; z_cpu_addr = 16'h0030;
    nv = 0; nc = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (z_vid_ack) nv++;
      if (z_cpu_ack) nc++;
    end
    check("f0_vid_acks", 64'(nv), 64'(6));
    check("f0_cpu_starved", 64'(nc), 64'(0));
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (z_vid_ack) got = 1;
    end
    check("f0_vid_ack_seen", 64'(got), 64'(1'b1));
    z_vid_req = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (z_cpu_ack) got = 1;
    end
    check("f0_cpu_done", 64'(got), 64'(1'b1));
    check("f0_cpu_rdata", 64'(z_cpu_rdata), 64'(pat(19'h00030)));
    z_cpu_req = 0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset pulsed during the WAIT cycle of a video read
    vid_req = 1; vid_addr = 19'h00100;
    @(negedge clk);
    check("rst_issue_cs", 64'(ram_cs), 64'(1'b1));
    @(negedge clk);
    reset = 1; vid_req = 0;
    #1;
    check("rst_async_outs", 64'(outs()), 64'(rst_exp));
    @(negedge clk);
    check("rst_held_outs", 64'(outs()), 64'(rst_exp));
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d_outs", k), 64'(outs()), 64'(rst_exp));
    end
    run_vec(2);

    // Back-to-back CPU reads, fields updated at the ack edge
    cpu_req = 1; cpu_rw = 1; cpu_page = 3'd0; cpu_addr = 16'h0000;
    nc = 0; ncs = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ram_cs) ncs++;
      if (cpu_ack) nc++;
      if (k == 1) check("b2b_addr0", 64'({ram_cs, ram_addr}), 64'({1'b1, 19'h00000}));
      if (k == 3) begin
        check("b2b_ack0", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, pat(19'd0)}));
        cpu_addr = 16'h0001;
      end
      if (k == 4) check("b2b_masked_cs", 64'(ram_cs), 64'(1'b0));
      if (k == 5) check("b2b_addr1", 64'({ram_cs, ram_addr}), 64'({1'b1, 19'h00001}));
      if (k == 7) begin
        check("b2b_ack1", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, pat(19'd1)}));
        cpu_req = 0;
      end
    end
    check("b2b_cs_count", 64'(ncs), 64'(2));
    check("b2b_ack_count", 64'(nc), 64'(2));

    // Randomized two-port traffic in a small shared window (pages 4/5, 0x40-0x4F)
    for (int i = 0; i < 32; i++) ref_mem[i] = pat({2'b10, i[4], 12'h004, i[3:0]});
    last_crd = pat(19'd1);
    c_busy = 0; v_busy = 0; c_wait = 0; v_wait = 0; prev_cs = 0; abort = 0; ntx = 0;
    for (int cyc = 0; cyc < NRND && !abort; cyc++) begin
      @(negedge clk);
      check("cs_single_cycle", 64'(ram_cs && prev_cs), 64'(1'b0));
      prev_cs = ram_cs;
      check("one_ack", 64'(cpu_ack && vid_ack), 64'(1'b0));
      if (ram_cs) begin
        s.a = ram_addr; s.rw = ram_rw; s.wd = ram_wdata;
        sq.push_back(s);
        check("strobe_read_eq_rw", 64'(ram_read), 64'(ram_rw));
      end else begin
        check("idle_strobes", 64'({ram_read, ram_rw}), 64'(2'b01));
      end
      if (cpu_ack) begin
        if (!c_busy || sq.size() == 0) begin
          check("cpu_spurious_ack", 64'(cpu_ack), 64'(1'b0));
        end else begin
          s = sq.pop_front();
          check("rnd_cpu_addr", 64'(s.a), 64'(c_phys));
          check("rnd_cpu_rw", 64'(s.rw), 64'(c_rd));
          if (c_rd) begin
            check("rnd_cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[{c_phys[16], c_phys[3:0]}]));
            last_crd = ref_mem[{c_phys[16], c_phys[3:0]}];
          end else begin
            check("rnd_cpu_wdata", 64'(s.wd), 64'(c_wd));
            check("rnd_cpu_rdata_hold", 64'(cpu_rdata), 64'(last_crd));
            ref_mem[{c_phys[16], c_phys[3:0]}] = c_wd;
          end
          c_busy = 0; ntx++;
        end
      end
      if (vid_ack) begin
        if (!v_busy || sq.size() == 0) begin
          check("vid_spurious_ack", 64'(vid_ack), 64'(1'b0));
        end else begin
          s = sq.pop_front();
          check("rnd_vid_addr", 64'({s.a, s.rw}), 64'({v_phys, 1'b1}));
          check("rnd_vid_rdata", 64'(vid_rdata), 64'(ref_mem[{v_phys[16], v_phys[3:0]}]));
          v_busy = 0; ntx++;
        end
      end
      if (c_busy) begin
        c_wait++;
        if (c_wait > 12) begin check("cpu_latency", 64'(c_wait), 64'(12)); abort = 1; end
      end
      if (v_busy) begin
        v_wait++;
        if (v_wait > 12) begin check("vid_latency", 64'(v_wait), 64'(12)); abort = 1; end
      end
      if (!c_busy) begin
        if (cyc < NRND - 24 && $urandom_range(0, 2) != 0) begin
          cpu_rw = 1'($urandom_range(0, 1));
          cpu_page = {2'b10, 1'($urandom_range(0, 1))};
          cpu_addr = {12'h004, 4'($urandom_range(0, 15))};
          cpu_wdata = 8'($urandom);
          cpu_req = 1;
          c_phys = {cpu_page, cpu_addr}; c_rd = cpu_rw; c_wd = cpu_wdata;
          c_busy = 1; c_wait = 0;
        end else begin
          cpu_req = 0;
        end
      end
      if (!v_busy) begin
        if (cyc < NRND - 24 && $urandom_range(0, 2) != 0) begin
          vid_addr = {2'b10, 1'($urandom_range(0, 1)), 12'h004, 4'($urandom_range(0, 15))};
          vid_req = 1;
          v_phys = vid_addr;
          v_busy = 1; v_wait = 0;
        end else begin
          vid_req = 0;
        end
      end
    end
    check("rnd_unacked_strobes", 64'(sq.size()), 64'(0));
    check("rnd_traffic", 64'(ntx >= 500), 64'(1'b1));
    cpu_req = 0; vid_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer in front of the single-port system RAM (19-bit byte address, 8-bit data, 1-cycle registered read; read data returns 0 when not reading). It shares the RAM between the CPU bus (read/write, 16-bit address plus 3-bit page) and the video fetch unit (read-only, 19-bit address). It drives the RAM control strobes for exactly one cycle per transaction and returns read data with a one-cycle ack pulse. It sits between the CPU/video blocks and the RAM in the top level.

## Interface
- FAIR, default 1: 1 = alternate grants when both ports are pending; 0 = video always wins.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU request, held until cpu_ack.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_page  in  3  bank select; forms physical address bits [18:16].
- cpu_addr  in  16  CPU address; forms physical address bits [15:0].
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse, for reads and writes.
- vid_req  in  1  video read request, held until vid_ack.
- vid_addr  in  19  physical read address.
- vid_rdata  out  8  read data, valid while vid_ack=1.
- vid_ack  out  1  one-cycle completion pulse.
- ram_cs  out  1  RAM chip select.
- ram_rw  out  1  0 = write.
- ram_read  out  1  read enable.
- ram_addr  out  19  RAM address.
- ram_wdata  out  8  data to the RAM.
- ram_rdata  in  8  RAM read data (registered in the RAM, 1-cycle latency).

## Operation
- States: IDLE, ISSUE, WAIT. A one-bit `last` register records the last port served (0 = CPU, 1 = video).
- IDLE: arbitrate among the unmasked pending requests.
  - One pending: grant it.
  - Both pending: with FAIR=1, grant the port not equal to `last`; with FAIR=0, grant video.
  - On a grant, latch the port, physical address, rw and wdata, then go to ISSUE.
- CPU physical address = {cpu_page, cpu_addr}. Video is always a read.
- ISSUE (one cycle): registered outputs are ram_cs=1, ram_addr/ram_wdata from the latched request.
  - Read: ram_rw=1, ram_read=1.
  - Write: ram_rw=0, ram_read=0.
  - Next state: WAIT.
- WAIT (one cycle): ram_cs=0, ram_read=0, ram_rw=1. ram_rdata is valid in this cycle.
  - At the WAIT-ending edge, register ram_rdata into the granted port's rdata (reads only; writes leave rdata unchanged), assert that port's ack for exactly the next cycle, and update `last`.
  - Next state: ISSUE directly if the other port is requesting (arbitrate at this edge, excluding the served port); otherwise IDLE.
- Masking: a port's req is ignored at the edge that ends its ack cycle. The requester updates its fields or drops req at that edge; its new request is sampled from the following edge onward.
- Outside ISSUE: ram_cs=0, ram_read=0, ram_rw=1. ram_addr and ram_wdata hold their last values.

## Timing
- Reset values: state=IDLE, last=0 (so video wins the first contention), ram_cs=0, ram_rw=1, ram_read=0, ram_addr=0, ram_wdata=0, cpu_ack=0, vid_ack=0, cpu_rdata=0, vid_rdata=0.
- Latency, with the request sampled at edge e0 in IDLE:
  - ISSUE strobes are visible in cycle e0–e1.
  - RAM samples at e1.
  - Data is valid on ram_rdata in cycle e1–e2.
  - Ack and rdata are visible in cycle e2–e3.
- Throughput: under two-port contention, one transaction every 2 cycles, alternating ports (FAIR=1). A single port alone gets one transaction per 4 cycles (IDLE, ISSUE, WAIT, ack/mask).
- No more than one ack is high in any cycle. ram_cs is high for exactly one cycle per transaction.
- Reset asserted mid-transaction: all outputs return to reset values immediately; the transaction is dropped with no ack. The RAM may already have been written if reset arrives after ISSUE.
- req dropping before ack is illegal. Behaviour is defined only as "the latched transaction completes and acks".

## Test plan
- CPU read: page=3, addr=0x1234, RAM[0x31234]=0xA5, cpu_req at e0 -> ram_cs/ram_read=1 with ram_addr=0x31234 for one cycle; cpu_ack=1 with cpu_rdata=0xA5 in cycle e2–e3 only.
- CPU write then read: write 0x5A to page 0 addr 0x0100 -> ram_rw=0, ram_read=0, ram_wdata=0x5A for one cycle, then ack; a subsequent read of the same address returns 0x5A and cpu_rdata stays unchanged across the write.
- Simultaneous req after reset, FAIR=1: vid_addr=0x10000 and cpu read 0x00010 -> video granted first, CPU ISSUE immediately after video WAIT; acks 2 cycles apart; both held high -> strict alternation.
- FAIR=0 with vid_req held continuously and cpu_req high -> only video transactions issue and cpu_ack never fires; drop vid_req -> CPU completes.
- Reset pulsed during WAIT of a video read -> vid_ack never asserts, all outputs at reset values on the next cycle, and a new request then completes normally.
- Back-to-back CPU reads to 0x00000 and 0x00001 with fields updated at the ack edge -> the masked edge causes no duplicate access; second ram_addr=0x00001; exactly two acks.
